// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the sync FIFO write-side arbiter.
// Holds the log2 helper, arbiter state enum and default sizes.
package sync_fifo_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_SIZE  = 8;
  localparam int DEF_DATA_DEPTH = 16;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first request at or
// after the pointer, searching circularly.
module rr_arbiter
  import sync_fifo_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = log2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one sync
// FIFO write port between NUM_REQ producers.
module fifo_wr_arbiter
  import sync_fifo_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int APT_SIZE   = log2(DATA_DEPTH),
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic                         fifo_full_i,
  input  logic [APT_SIZE:0]            fifo_usedw_i,
  output logic                         fifo_wr_o,
  output logic [DATA_SIZE-1:0]         fifo_din_o,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic                         busy_o,
  output logic [NUM_REQ-1:0]           trunc_o
);

  localparam int PTR_W = log2(NUM_REQ);
  localparam int CNT_W = log2(MAX_BURST) + 1;
  localparam int FW    = APT_SIZE + 1;

  arb_state_e           state;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   trunc_q;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gidx;
  logic [PTR_W-1:0]     nxt_ptr;
  logic [CNT_W-1:0]     beat_cnt;
  logic [FW-1:0]        free;
  logic                 admit;
  logic                 last_g;
  logic                 end_burst;
  logic [DATA_SIZE-1:0] mux;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr (
    .req_i(req_valid_i),
    .ptr_i(rr_ptr),
    .gnt_o(arb_gnt)
  );

  // Admit only if a worst-case burst fits.
  assign free  = FW'(DATA_DEPTH) - fifo_usedw_i;
  assign admit = (free >= FW'(MAX_BURST));

  always_comb begin
    mux  = '0;
    gidx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        mux  = req_data_i[k*DATA_SIZE +: DATA_SIZE];
        gidx = PTR_W'(k);
      end
    end
  end

  assign nxt_ptr = (gidx == PTR_W'(NUM_REQ - 1))
                 ? '0 : gidx + 1'b1;

  assign req_ready_o = (rst_i || fifo_full_i)
                     ? '0 : grant_q;
  assign fifo_wr_o   = |(req_valid_i & req_ready_o);
  assign fifo_din_o  = rst_i ? '0 : mux;

  assign last_g    = |(req_last_i & grant_q);
  assign end_burst = last_g ||
    (beat_cnt == CNT_W'(MAX_BURST - 1));

  assign busy_o  = (state == BURST);
  assign grant_o = grant_q;
  assign trunc_o = trunc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      grant_q  <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      trunc_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid_i && admit) begin
            grant_q  <= arb_gnt;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (fifo_wr_o) begin
            if (end_burst) begin
              state    <= IDLE;
              grant_q  <= '0;
              rr_ptr   <= nxt_ptr;
              beat_cnt <= '0;
              if (!last_g) trunc_q <= trunc_q | grant_q;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter with a
// packet-level reference model and a queue-based FIFO.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int MAXB  = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          full;
  logic [4:0]    usedw;
  logic          wr;
  logic [DW-1:0] din;
  logic [N-1:0]  grant;
  logic          busy;
  logic [N-1:0]  trunc;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_SIZE (DW),
    .DATA_DEPTH(DEPTH),
    .APT_SIZE  (4),
    .MAX_BURST (MAXB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .fifo_full_i (full),
    .fifo_usedw_i(usedw),
    .fifo_wr_o   (wr),
    .fifo_din_o  (din),
    .grant_o     (grant),
    .busy_o      (busy),
    .trunc_o     (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // producer beat queues: {last, data}
  logic [8:0] pq [N][$];
  logic [7:0] fq [$];
  logic [N-1:0] gap;
  logic drain, ovr_full, ovr_used_en;
  logic [4:0] ovr_used;

  // reference model: packet-level view
  bit   m_busy;
  int   m_owner, m_beats, m_ptr;
  logic [N-1:0] m_trunc;

  logic [N-1:0] hs_cap;
  logic wr_cap;
  logic [7:0] din_cap;
  logic [N-1:0] prev_g;
  int   starts [$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic add_pkt(int k, int len, logic [7:0] base);
    for (int i = 0; i < len; i++)
      pq[k].push_back({(i == len - 1), 8'(base + i)});
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      logic v;
      v = (pq[k].size() > 0) && !gap[k];
      req_valid[k] = v;
      req_last[k]  = v ? pq[k][0][8] : 1'b0;
      req_data[k*DW +: DW] = (pq[k].size() > 0)
                           ? pq[k][0][7:0] : 8'h00;
    end
    usedw = ovr_used_en ? ovr_used : 5'(fq.size());
    full  = ovr_full || (fq.size() >= DEPTH);
  endtask

  task automatic pre();
    logic [N-1:0] e_g, e_rdy;
    logic e_wr;
    logic [7:0] e_din;
    drive();
    #2;
    e_g   = m_busy ? N'(1 << m_owner) : '0;
    e_rdy = (!rst && m_busy && !full) ? e_g : '0;
    e_wr  = !rst && m_busy && !full && req_valid[m_owner];
    e_din = (!rst && m_busy)
          ? req_data[m_owner*DW +: DW] : 8'h00;
    chk("grant", 32'(grant), 32'(e_g));
    chk("ready", 32'(req_ready), 32'(e_rdy));
    chk("wr", 32'(wr), 32'(e_wr));
    chk("din", 32'(din), 32'(e_din));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("trunc", 32'(trunc), 32'(m_trunc));
    hs_cap  = req_valid & req_ready;
    wr_cap  = wr;
    din_cap = din;
    if (grant != 0 && prev_g == 0)
      for (int k = 0; k < N; k++)
        if (grant[k]) starts.push_back(k);
    prev_g = grant;
  endtask

  task automatic model_seq();
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_beats = 0; m_trunc = '0;
    end else if (!m_busy) begin
      if (|req_valid && (DEPTH - int'(usedw)) >= MAXB) begin
        bit found;
        found = 0;
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (!found && req_valid[k]) begin
            m_owner = k; found = 1;
          end
        end
        m_busy = 1; m_beats = 0;
      end
    end else if (!full && req_valid[m_owner]) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == MAXB) begin
        if (!req_last[m_owner]) m_trunc[m_owner] = 1'b1;
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic post();
    @(posedge clk);
    model_seq();
    for (int k = 0; k < N; k++)
      if (hs_cap[k] && pq[k].size() > 0) void'(pq[k].pop_front());
    if (drain && fq.size() > 0) void'(fq.pop_front());
    if (wr_cap) fq.push_back(din_cap);
    #1;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic run_done(int bound);
    int n, left;
    n = 0;
    left = 1;
    while (left != 0 && n < bound) begin
      cycle();
      n++;
      left = int'(m_busy);
      for (int k = 0; k < N; k++) left += pq[k].size();
    end
    chk("timeout", 32'(left), 32'd0);
  endtask

  initial begin
    rst = 1'b1; gap = '0; drain = 1'b1;
    ovr_full = 1'b0; ovr_used_en = 1'b0; ovr_used = '0;
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    m_trunc = '0; prev_g = '0;
    for (int k = 0; k < N; k++) begin
      add_pkt(k, 2, 8'(8'h80 + 16 * k));
      add_pkt(k, 2, 8'(8'h88 + 16 * k));
    end
    drive();
    @(posedge clk); #1;

    // reset with every producer valid
    cycle();
    cycle();
    rst = 1'b0;

    // round robin across 2-beat packets
    starts.delete();
    run_done(100);
    chk("rr_n", 32'(starts.size()), 32'd8);
    chk("rr0", 32'(starts[0]), 32'd0);
    chk("rr1", 32'(starts[1]), 32'd1);
    chk("rr2", 32'(starts[2]), 32'd2);
    chk("rr3", 32'(starts[3]), 32'd3);
    chk("rr4", 32'(starts[4]), 32'd0);

    // admission threshold
    ovr_used_en = 1'b1; ovr_used = 5'd13;
    add_pkt(1, 2, 8'h10);
    for (int i = 0; i < 3; i++) cycle();
    chk("adm_hold", 32'(grant), 32'd0);
    ovr_used = 5'd12;
    cycle();
    #2;
    chk("adm_go", 32'(grant), 32'b0010);
    run_done(50);
    ovr_used_en = 1'b0;
    fq.delete();

    // truncation at MAX_BURST
    drain = 1'b0;
    add_pkt(2, 6, 8'h20);
    run_done(50);
    chk("trunc2", 32'(trunc), 32'b0100);
    chk("trunc_n", 32'(fq.size()), 32'd6);
    for (int i = 0; i < 6 && i < fq.size(); i++)
      chk("trunc_d", 32'(fq[i]), 32'(8'h20 + i));
    fq.delete();

    // full stall mid-burst
    add_pkt(3, 4, 8'h30);
    cycle();
    cycle();
    ovr_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("stl_rdy", 32'(req_ready), 32'd0);
      chk("stl_wr", 32'(wr), 32'd0);
      chk("stl_g", 32'(grant), 32'b1000);
      post();
    end
    ovr_full = 1'b0;
    run_done(50);
    chk("stl_n", 32'(fq.size()), 32'd4);
    for (int i = 0; i < 4 && i < fq.size(); i++)
      chk("stl_d", 32'(fq[i]), 32'(8'h30 + i));
    fq.delete();

    // reset in the middle of a burst
    add_pkt(2, 4, 8'h40);
    cycle();
    cycle();
    cycle();
    add_pkt(1, 2, 8'h50);
    add_pkt(3, 2, 8'h60);
    rst = 1'b1;
    pre();
    chk("mrst_wr", 32'(wr), 32'd0);
    post();
    rst = 1'b0;
    chk("mrst_fq", 32'(fq.size()), 32'd2);
    pre();
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_tr", 32'(trunc), 32'd0);
    post();
    #2;
    chk("mrst_g", 32'(grant), 32'b0010);
    drain = 1'b1;
    run_done(100);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (pq[k].size() < 3 && $urandom_range(0, 3) == 0)
          add_pkt(k, $urandom_range(1, 6), 8'($urandom));
        gap[k] = ($urandom_range(0, 4) == 0);
      end
      drain    = 1'($urandom_range(0, 1));
      ovr_full = ($urandom_range(0, 15) == 0);
      cycle();
    end
    gap = '0; ovr_full = 1'b0; drain = 1'b1;
    run_done(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one sync FIFO (depth DATA_DEPTH, width DATA_SIZE) between NUM_REQ producers using packet-granular round-robin arbitration.
- A grant is held for a whole packet, up to MAX_BURST beats, so packets never interleave inside the FIFO.
- A new packet is admitted only when the FIFO has room for a worst-case burst, so granted bursts normally run without stalling.
- Sits directly in front of the FIFO instance: drives its write strobe and data; reads its full flag and fill count.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_SIZE, 8, data width in bits; matches the FIFO.
- DATA_DEPTH, 16, FIFO depth in entries; matches the FIFO.
- APT_SIZE, log2(DATA_DEPTH), FIFO pointer width; the fill count is APT_SIZE+1 bits.
- MAX_BURST, 4, maximum beats per grant (1..DATA_DEPTH).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-producer beat valid.
- req_last_i  in  NUM_REQ  per-producer last beat of packet; qualified by valid.
- req_data_i  in  NUM_REQ*DATA_SIZE  per-producer data; producer k uses slice [k*DATA_SIZE +: DATA_SIZE].
- req_ready_o  out  NUM_REQ  per-producer beat accept.
- fifo_full_i  in  1  FIFO full flag.
- fifo_usedw_i  in  APT_SIZE+1  FIFO fill count.
- fifo_wr_o  out  1  FIFO write strobe.
- fifo_din_o  out  DATA_SIZE  FIFO write data.
- grant_o  out  NUM_REQ  one-hot current owner; all zeros when idle.
- busy_o  out  1  high while a burst is in progress.
- trunc_o  out  NUM_REQ  sticky per-producer flag: packet cut at MAX_BURST.

Behaviour:
- Reset (rst_i=1 at a rising edge) clears all state:
  - state=IDLE, grant_o=0, rr pointer=0, beat counter=0, trunc_o=0.
  - req_ready_o=0, fifo_wr_o=0, fifo_din_o=0 while rst_i is high.
- Reset asserted mid-burst abandons the burst immediately. No write occurs in the reset cycle; the partial packet stays in the FIFO.
- Free space: free = DATA_DEPTH - fifo_usedw_i, computed at APT_SIZE+1 bits with no wrap.
- Admission: admit = (free >= MAX_BURST).
- State IDLE:
  - If any req_valid_i is high and admit is true, pick the first valid producer at or after the rr pointer (circular search).
  - Register that producer's one-hot grant, clear the beat counter, go to BURST.
  - Otherwise stay in IDLE.
  - No beats transfer in IDLE, so there is one bubble cycle between packets.
- State BURST:
  - req_ready_o[g] = !fifo_full_i for the granted producer g; 0 for all others.
  - fifo_wr_o = req_valid_i[g] & req_ready_o[g], combinational.
  - fifo_din_o = slice g of req_data_i, combinational.
  - A beat transfers when fifo_wr_o=1; the beat counter then increments.
  - Burst ends on a transferring beat when req_last_i[g]=1, or when the beat counter equals MAX_BURST-1 (the MAX_BURST-th beat).
  - If the burst ends on the MAX_BURST-th beat with req_last_i[g]=0, set trunc_o[g]. The producer's remaining beats form a new packet and arbitrate again.
  - At burst end: next state IDLE, rr pointer = (g+1) mod NUM_REQ, grant cleared.
  - A valid drop mid-burst holds the grant and waits; no timeout.
  - If fifo_full_i is high, ready is 0 and the arbiter stalls. This is only possible if the FIFO is written from elsewhere or MAX_BURST exceeds the free space.
- Outputs:
  - grant_o and busy_o are registered.
  - busy_o = (state==BURST).
  - grant_o, req_ready_o and fifo_wr_o are never active for a non-granted producer.
- Rules:
  - Grant may not change while state==BURST.
  - The beat counter is clog2(MAX_BURST)+1 bits and never exceeds MAX_BURST-1.
  - trunc_o bits clear only on reset.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - the log2 helper function;
  - the arbiter state enum (IDLE, BURST);
  - default width constants.
- One natural sub-module: rr_arbiter. It is combinational: request vector plus rr pointer in, one-hot grant out.
- The top level holds the FSM, beat counter, admission check and data mux.

Test Plan:
1. Reset: rst_i=1 for 2 cycles with all req_valid_i=1 -> fifo_wr_o=0, grant_o=0, busy_o=0, trunc_o=0 throughout.
2. Round-robin: all 4 producers present 2-beat packets continuously, FIFO drained -> grant order 0,1,2,3,0. Each burst has 2 writes, then one idle cycle between bursts.
3. Admission: fifo_usedw_i=13 (free=3 < MAX_BURST=4) with producer 1 valid -> no grant. Drop usedw to 12 -> grant_o=4'b0010 on the next edge.
4. Truncation: producer 2 sends 6 beats with last only on beat 6 -> first burst writes 4 beats and trunc_o[2]=1. After one idle cycle, a second grant writes beats 5-6.
5. Full stall: mid-burst, force fifo_full_i=1 for 3 cycles -> req_ready_o=0 and fifo_wr_o=0 for 3 cycles, grant unchanged. The burst resumes with no data loss or duplication.
6. Mid-burst reset: assert rst_i after 2 beats of a 4-beat packet -> no write in the reset cycle, state=IDLE, rr pointer=0. The next grant goes to the lowest-index valid producer.
